pipe_mips32: RTL and testbench
==============================

PIPE_MIPS32 -- requirements
Module: pipe_mips32

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: number of 32-bit words in the unified instruction/data memory (word-addressed).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have no other ports; state SHALL be visible by hierarchical name: Reg[0:31] (32-bit), Mem[0:MEM_WORDS-1] (32-bit), PC (32-bit word index), HALTED (1 bit), TAKEN_BRANCH (1 bit).

Function
REQ-005 SHALL be a 5-stage pipeline (IF, ID, EX, MEM, WB), one instruction per cycle; each stage latch carries a valid bit, and an invalid stage (bubble) changes no state.
REQ-006 SHALL decode fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0] sign-extended to 32 bits.
REQ-007 SHALL implement R-type (dest rd = rs op rt): ADD 0, SUB 1, AND 2, OR 3, SLT 4 (signed, result 1/0), MUL 5 (low 32 bits of product).
REQ-008 SHALL implement I-type (dest rt): LW 8 (rt = Mem[rs+imm]), SW 9 (Mem[rs+imm] = rt), ADDI 10, SUBI 11, SLTI 12 (signed).
REQ-009 SHALL implement BNEQZ 13 (taken if rs != 0) and BEQZ 14 (taken if rs == 0), with target = branch PC + 1 + imm.
REQ-010 SHALL implement HLT 63; any other opcode SHALL be a NOP.
REQ-011 SHALL wrap all arithmetic modulo 2^32; memory address SHALL be (rs+imm) modulo MEM_WORDS; PC SHALL increment by 1 per fetch.
REQ-012 SHALL treat R0 as constant zero: reads return 0, writes are discarded.
REQ-013 SHALL forward results to EX operands (including branch condition and SW data), priority EX/MEM over MEM/WB, source ALU result or loaded data.
REQ-014 SHALL make a register written in WB visible to an ID read in the same cycle (write-through).
REQ-015 SHALL stall one cycle when the instruction in ID reads the destination of an LW in EX: PC and IF/ID hold, and a bubble enters ID/EX.
REQ-016 SHALL resolve branches in EX. When taken, PC <= target on that edge, the two younger instructions (IF/ID, ID/EX) SHALL be flushed to bubbles, and TAKEN_BRANCH SHALL be 1 for exactly that following cycle, otherwise 0.
REQ-017 SHALL stop fetching once a valid HLT is in IF/ID: PC holds and IF supplies bubbles; older instructions drain normally.
REQ-018 SHALL set HALTED=1 on the edge HLT completes WB; while HALTED=1, PC, Reg, Mem and all latches SHALL be frozen.
REQ-019 SHALL resolve a stall and a taken branch in the same cycle in favour of the branch (flush overrides hold).

Reset
REQ-020 While rst_n=0 (asynchronous), the design SHALL force PC=0, HALTED=0, TAKEN_BRANCH=0 and all stage valid bits to 0.
REQ-021 Reset SHALL NOT modify Reg or Mem, so preloaded programs and data survive; execution SHALL start by fetching Mem[0] on the first rising edge after rst_n rises.
REQ-022 Reset asserted mid-program SHALL discard all in-flight instructions; any store that has not yet completed MEM SHALL NOT occur.

Verification
REQ-023 Mem[0..7]=28010078, 0c631800, 20220000, 0c631800, 2842002d, 0c631800, 24220001, fc000000; Mem[120]=85; Reg cleared -> Mem[121]=130, Mem[120]=85, R1=120, R2=130, HALTED=1 by edge 12.
REQ-024 Back-to-back dependents: ADDI R1,R0,10; ADDI R2,R1,5; ADD R3,R1,R2; HLT -> R3=25 with no NOPs.
REQ-025 Load-use: LW R2,0(R1) immediately followed by ADDI R3,R2,1 with Mem[R1]=7 -> R3=8, exactly one bubble inserted.
REQ-026 Loop: R1=3, body SUBI R1,R1,1, then BNEQZ R1 back to the body -> loop exits with R1=0. The two instructions after the branch SHALL never write state while it is taken, and TAKEN_BRANCH pulses once per taken branch.
REQ-027 R-type/edge cases: SUB 0-1 = FFFFFFFF; SLT -1,1 = 1; MUL 0x10000*0x10000 = 0; ADDI R0,R0,5 leaves R0=0.
REQ-028 Reset pulsed mid-program with a store pending -> store suppressed, PC=0, HALTED=0, program reruns from Mem[0].

Source files
------------

// File: rtl/pipe_mips32.sv
// pipe_mips32: five-stage in-order MIPS-like core over one unified word memory.
// EX-stage forwarding, single-cycle load-use stall, branches resolved in EX.
module pipe_mips32 #(
    parameter int MEM_WORDS = 1024
) (
    input logic clk,
    input logic rst_n
);
    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_SLT   = 6'd4;
    localparam logic [5:0] OP_MUL   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd8;
    localparam logic [5:0] OP_SW    = 6'd9;
    localparam logic [5:0] OP_ADDI  = 6'd10;
    localparam logic [5:0] OP_SUBI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_BNEQZ = 6'd13;
    localparam logic [5:0] OP_BEQZ  = 6'd14;
    localparam logic [5:0] OP_HLT   = 6'd63;

    typedef struct packed {
        logic        valid;
        logic [31:0] ir;
        logic [31:0] npc;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic        we;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] npc;
    } id_ex_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  op;
        logic [4:0]  dest;
        logic        we;
        logic [31:0] alu;
        logic [31:0] b;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  op;
        logic [4:0]  dest;
        logic        we;
        logic [31:0] alu;
        logic [31:0] lmd;
    } mem_wb_t;

    logic [31:0] Reg [0:31];
    logic [31:0] Mem [0:MEM_WORDS-1];
    logic [31:0] PC;
    logic        HALTED;
    logic        TAKEN_BRANCH;
    logic        fetch_stop;

    if_id_t  if_id;
    id_ex_t  id_ex, id_dec;
    ex_mem_t ex_mem;
    mem_wb_t mem_wb;

    logic [5:0]    op;
    logic [4:0]    rs, rt, rd;
    logic          is_r, is_lw, is_sw, is_imm, is_br;
    logic          hlt_id, stall, taken, wb_en;
    logic [31:0]   wb_val, fa, fb, alu, target;
    logic [AW-1:0] fidx, eidx;

    assign op     = if_id.ir[31:26];
    assign rs     = if_id.ir[25:21];
    assign rt     = if_id.ir[20:16];
    assign rd     = if_id.ir[15:11];
    assign is_r   = op <= OP_MUL;
    assign is_lw  = op == OP_LW;
    assign is_sw  = op == OP_SW;
    assign is_imm = op >= OP_ADDI && op <= OP_SLTI;
    assign is_br  = op == OP_BNEQZ || op == OP_BEQZ;
    assign hlt_id = if_id.valid && op == OP_HLT;

    assign wb_en  = mem_wb.valid && mem_wb.we;
    assign wb_val = (mem_wb.op == OP_LW) ? mem_wb.lmd : mem_wb.alu;
    assign fidx   = AW'(PC % MEM_WORDS);
    assign eidx   = AW'(ex_mem.alu % MEM_WORDS);

    // Register reads see the value being written back this same cycle.
    always_comb begin
        id_dec       = '0;
        id_dec.valid = if_id.valid;
        id_dec.op    = op;
        id_dec.rs    = rs;
        id_dec.rt    = rt;
        id_dec.dest  = is_r ? rd : rt;
        id_dec.we    = (is_r || is_lw || is_imm) && id_dec.dest != 5'd0;
        id_dec.a     = Reg[rs];
        id_dec.b     = Reg[rt];
        if (wb_en && mem_wb.dest == rs) id_dec.a = wb_val;
        if (wb_en && mem_wb.dest == rt) id_dec.b = wb_val;
        if (rs == 5'd0) id_dec.a = '0;
        if (rt == 5'd0) id_dec.b = '0;
        id_dec.imm   = {{16{if_id.ir[15]}}, if_id.ir[15:0]};
        id_dec.npc   = if_id.npc;
    end

    assign stall = if_id.valid && id_ex.valid && id_ex.op == OP_LW && id_ex.we
        && (((is_r || is_lw || is_sw || is_imm || is_br) && rs == id_ex.dest)
        || ((is_r || is_sw) && rt == id_ex.dest));

    always_comb begin
        fa = id_ex.a;
        fb = id_ex.b;
        if (wb_en && mem_wb.dest == id_ex.rs) fa = wb_val;
        if (wb_en && mem_wb.dest == id_ex.rt) fb = wb_val;
        if (ex_mem.valid && ex_mem.we && ex_mem.dest == id_ex.rs) fa = ex_mem.alu;
        if (ex_mem.valid && ex_mem.we && ex_mem.dest == id_ex.rt) fb = ex_mem.alu;
    end

    always_comb begin
        alu = '0;
        case (id_ex.op)
            OP_ADD:  alu = fa + fb;
            OP_SUB:  alu = fa - fb;
            OP_AND:  alu = fa & fb;
            OP_OR:   alu = fa | fb;
            OP_SLT:  alu = {31'b0, $signed(fa) < $signed(fb)};
            OP_MUL:  alu = fa * fb;
            OP_LW,
            OP_SW,
            OP_ADDI: alu = fa + id_ex.imm;
            OP_SUBI: alu = fa - id_ex.imm;
            OP_SLTI: alu = {31'b0, $signed(fa) < $signed(id_ex.imm)};
            default: alu = '0;
        endcase
    end

    assign taken = id_ex.valid
        && ((id_ex.op == OP_BNEQZ && fa != '0)
        || (id_ex.op == OP_BEQZ && fa == '0));
    assign target = id_ex.npc + id_ex.imm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            fetch_stop   <= 1'b0;
            if_id        <= '0;
            id_ex        <= '0;
            ex_mem       <= '0;
            mem_wb       <= '0;
        end else if (!HALTED) begin
            HALTED        <= mem_wb.valid && mem_wb.op == OP_HLT;
            TAKEN_BRANCH  <= taken;
            mem_wb.valid  <= ex_mem.valid;
            mem_wb.op     <= ex_mem.op;
            mem_wb.dest   <= ex_mem.dest;
            mem_wb.we     <= ex_mem.we;
            mem_wb.alu    <= ex_mem.alu;
            mem_wb.lmd    <= Mem[eidx];
            ex_mem.valid  <= id_ex.valid;
            ex_mem.op     <= id_ex.op;
            ex_mem.dest   <= id_ex.dest;
            ex_mem.we     <= id_ex.we;
            ex_mem.alu    <= alu;
            ex_mem.b      <= fb;
            if (taken) begin
                PC    <= target;
                if_id <= '0;
                id_ex <= '0;
            end else if (stall) begin
                id_ex <= '0;
            end else begin
                id_ex <= id_dec;
                if (fetch_stop || hlt_id) begin
                    fetch_stop <= 1'b1;
                    if_id      <= '0;
                end else begin
                    if_id.valid <= 1'b1;
                    if_id.ir    <= Mem[fidx];
                    if_id.npc   <= PC + 32'd1;
                    PC          <= PC + 32'd1;
                end
            end
        end
    end

    // Architectural storage survives reset; cleared valid bits block writes.
    always_ff @(posedge clk) begin
        if (!HALTED && ex_mem.valid && ex_mem.op == OP_SW)
            Mem[eidx] <= ex_mem.b;
        if (!HALTED && wb_en)
            Reg[mem_wb.dest] <= wb_val;
    end
endmodule

// File: tb/tb_pipe_mips32.sv
// Bench for pipe_mips32: preloads programs, runs to HLT, then drains
// a scoreboard of expected register and memory contents.
module tb_pipe_mips32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    int taken_cnt = 0;

    typedef struct {
        bit          is_mem;
        int          idx;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_mips32 #(.MEM_WORDS(1024)) dut (
        .clk(clk),
        .rst_n(rst_n)
    );

    always @(negedge clk) if (rst_n && dut.TAKEN_BRANCH) taken_cnt++;

    function automatic logic [31:0] enc_r(int op, int rd, int rs, int rt);
        return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'b0};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rt, int rs, int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    task automatic push(bit m, int idx, logic [31:0] v, string nm);
        exp_t e;
        e.is_mem = m;
        e.idx = idx;
        e.val = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic clear_state();
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) dut.Mem[i] = '0;
        for (int i = 0; i < 32; i++) dut.Reg[i] = '0;
        sb.delete();
        taken_cnt = 0;
    endtask

    task automatic load(input logic [31:0] prog[$]);
        foreach (prog[i]) dut.Mem[i] = prog[i];
    endtask

    task automatic run(output int cycles, output bit done);
        @(negedge clk);
        rst_n = 1'b1;
        cycles = 0;
        done = 1'b0;
        repeat (300) begin
            @(posedge clk);
            #1;
            cycles++;
            if (dut.HALTED) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clear_state();
        dut.Reg[5] = 32'h1234;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dut.PC !== 32'd3) begin
            n_fail++;
            $display("FAIL reset_pre_pc got %0d exp 3", dut.PC);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut.PC !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_pc got %0d exp 0", dut.PC);
        end
        n_checks++;
        if (dut.HALTED !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_halted got %b exp 0", dut.HALTED);
        end
        n_checks++;
        if (dut.TAKEN_BRANCH !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_taken got %b exp 0", dut.TAKEN_BRANCH);
        end
        n_checks++;
        if (dut.Reg[5] !== 32'h1234) begin
            n_fail++;
            $display("FAIL reset_keeps_reg got %h exp 00001234", dut.Reg[5]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (dut.PC !== 32'd1) begin
            n_fail++;
            $display("FAIL reset_first_fetch got %0d exp 1", dut.PC);
        end
    endtask

    task automatic test_program();
        int cyc;
        bit done;
        logic [31:0] prog[$] = '{32'h28010078, 32'h0c631800, 32'h20220000,
            32'h0c631800, 32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
        clear_state();
        load(prog);
        dut.Mem[120] = 32'd85;
        push(1, 121, 32'd130, "prog_mem121");
        push(1, 120, 32'd85, "prog_mem120");
        push(0, 1, 32'd120, "prog_r1");
        push(0, 2, 32'd130, "prog_r2");
        run(cyc, done);
        n_checks++;
        if (!done || cyc > 12) begin
            n_fail++;
            $display("FAIL prog_halt_edge got %0d done %b exp <=12", cyc, done);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dut.PC !== 32'd8 || dut.HALTED !== 1'b1) begin
            n_fail++;
            $display("FAIL prog_frozen pc %0d halted %b exp 8 1", dut.PC, dut.HALTED);
        end
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] got = e.is_mem ? dut.Mem[e.idx] : dut.Reg[e.idx];
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s got %h exp %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit done;
        logic [31:0] prog[$];
        clear_state();
        prog = '{enc_i(10, 1, 0, 10), enc_i(10, 2, 1, 5),
            enc_r(0, 3, 1, 2), enc_i(63, 0, 0, 0)};
        load(prog);
        push(0, 1, 32'd10, "b2b_r1");
        push(0, 2, 32'd15, "b2b_r2");
        push(0, 3, 32'd25, "b2b_r3");
        run(cyc, done);
        n_checks++;
        if (!done || cyc != 8) begin
            n_fail++;
            $display("FAIL b2b_cycles got %0d done %b exp 8", cyc, done);
        end
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] got = e.is_mem ? dut.Mem[e.idx] : dut.Reg[e.idx];
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s got %h exp %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_load_use();
        int cyc;
        bit done;
        logic [31:0] prog[$];
        clear_state();
        prog = '{enc_i(10, 1, 0, 100), enc_i(8, 2, 1, 0),
            enc_i(10, 3, 2, 1), enc_i(63, 0, 0, 0)};
        load(prog);
        dut.Mem[100] = 32'd7;
        push(0, 2, 32'd7, "lu_r2");
        push(0, 3, 32'd8, "lu_r3");
        run(cyc, done);
        n_checks++;
        if (!done || cyc != 9) begin
            n_fail++;
            $display("FAIL lu_one_bubble got %0d done %b exp 9", cyc, done);
        end
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] got = e.is_mem ? dut.Mem[e.idx] : dut.Reg[e.idx];
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s got %h exp %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_loop();
        int cyc;
        bit done;
        logic [31:0] prog[$];
        clear_state();
        prog = '{enc_i(10, 1, 0, 3), enc_i(11, 1, 1, 1), enc_i(13, 0, 1, -2),
            enc_i(10, 5, 5, 1), enc_i(10, 6, 6, 1), enc_i(63, 0, 0, 0)};
        load(prog);
        push(0, 1, 32'd0, "loop_r1");
        push(0, 5, 32'd1, "loop_shadow1");
        push(0, 6, 32'd1, "loop_shadow2");
        run(cyc, done);
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL loop_timeout got %0d cycles exp halt", cyc);
        end
        n_checks++;
        if (taken_cnt != 2) begin
            n_fail++;
            $display("FAIL loop_taken_pulses got %0d exp 2", taken_cnt);
        end
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] got = e.is_mem ? dut.Mem[e.idx] : dut.Reg[e.idx];
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s got %h exp %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_edge_cases();
        int cyc;
        bit done;
        logic [31:0] prog[$];
        clear_state();
        prog = '{enc_i(10, 1, 0, 1), enc_r(1, 2, 0, 1), enc_r(4, 3, 2, 1),
            enc_i(10, 4, 0, 256), enc_r(5, 4, 4, 4), enc_r(5, 5, 4, 4),
            enc_i(10, 0, 0, 5), enc_r(0, 6, 0, 0), enc_i(10, 7, 0, 12),
            enc_i(10, 8, 0, 10), enc_r(2, 9, 7, 8), enc_r(3, 10, 7, 8),
            enc_i(12, 11, 2, 0), enc_i(11, 12, 0, 1), enc_i(14, 0, 0, 1),
            enc_i(10, 13, 0, 1), enc_i(10, 14, 0, 2), enc_i(20, 15, 0, 7),
            enc_i(63, 0, 0, 0)};
        load(prog);
        push(0, 2, 32'hffffffff, "edge_sub");
        push(0, 3, 32'd1, "edge_slt");
        push(0, 4, 32'h00010000, "edge_mul_small");
        push(0, 5, 32'd0, "edge_mul_wrap");
        push(0, 0, 32'd0, "edge_r0");
        push(0, 6, 32'd0, "edge_r0_read");
        push(0, 9, 32'd8, "edge_and");
        push(0, 10, 32'd14, "edge_or");
        push(0, 11, 32'd1, "edge_slti");
        push(0, 12, 32'hffffffff, "edge_subi");
        push(0, 13, 32'd0, "edge_beqz_skip");
        push(0, 14, 32'd2, "edge_beqz_target");
        push(0, 15, 32'd0, "edge_nop_op");
        run(cyc, done);
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL edge_timeout got %0d cycles exp halt", cyc);
        end
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] got = e.is_mem ? dut.Mem[e.idx] : dut.Reg[e.idx];
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s got %h exp %h", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit done;
        logic [31:0] prog[$];
        clear_state();
        prog = '{enc_i(10, 1, 0, 100), enc_i(10, 2, 0, 55),
            enc_i(9, 2, 1, 0), enc_i(63, 0, 0, 0)};
        load(prog);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (dut.Mem[100] !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_store_suppressed got %h exp 0", dut.Mem[100]);
        end
        n_checks++;
        if (dut.PC !== 32'd0 || dut.HALTED !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_state pc %0d halted %b exp 0 0", dut.PC, dut.HALTED);
        end
        push(1, 100, 32'd55, "mid_rerun_store");
        push(0, 1, 32'd100, "mid_rerun_r1");
        run(cyc, done);
        n_checks++;
        if (!done || cyc != 8) begin
            n_fail++;
            $display("FAIL mid_rerun_cycles got %0d done %b exp 8", cyc, done);
        end
        while (sb.size() > 0) begin
            exp_t e = sb.pop_front();
            logic [31:0] got = e.is_mem ? dut.Mem[e.idx] : dut.Reg[e.idx];
            n_checks++;
            if (got !== e.val) begin
                n_fail++;
                $display("FAIL %s got %h exp %h", e.name, got, e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_back_to_back();
        test_load_use();
        test_loop();
        test_edge_cases();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
